// File: rtl/i3c_table_mem_pkg.sv
// Shared types and constants for the i3c DAT/DCT table memories.
// Optional macro I3C_TABLE_PARITY_EN adds per-lane parity storage in the table RAM.
package i3c_table_mem_pkg;

    localparam int DatTableWidth = 64;
    localparam int DctTableWidth = 128;
    localparam int TableMaskLane = 32;
    localparam int DatTableDepth = 128;
    localparam int DctTableDepth = 128;
    localparam int DatTableAw    = $clog2(DatTableDepth);
    localparam int DctTableAw    = $clog2(DctTableDepth);

    typedef struct packed {
        logic                                    req;
        logic                                    write;
        logic [DatTableAw-1:0]                   addr;
        logic [DatTableWidth-1:0]                wdata;
        logic [DatTableWidth/TableMaskLane-1:0]  wmask;
    } table_port_req_t;

    typedef struct packed {
        logic                                    req;
        logic                                    write;
        logic [DctTableAw-1:0]                   addr;
        logic [DctTableWidth-1:0]                wdata;
        logic [DctTableWidth/TableMaskLane-1:0]  wmask;
    } dct_table_port_req_t;

endpackage

// File: rtl/i3c_table_mem_if.sv
// Requester-side bus of the shared table memory; master = requesters, slave = memory.
// Optional macro I3C_TABLE_PARITY_EN only changes what rerror_o can report.
interface i3c_table_mem_if
    import i3c_table_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int AW        = DatTableAw,
    parameter int WIDTH     = DatTableWidth,
    parameter int MW        = DatTableWidth / TableMaskLane
);
    logic [NUM_PORTS-1:0]       req_i;
    logic [NUM_PORTS-1:0]       gnt_o;
    logic [NUM_PORTS-1:0]       write_i;
    logic [NUM_PORTS*AW-1:0]    addr_i;
    logic [NUM_PORTS*WIDTH-1:0] wdata_i;
    logic [NUM_PORTS*MW-1:0]    wmask_i;
    logic [NUM_PORTS-1:0]       rvalid_o;
    logic [WIDTH-1:0]           rdata_o;
    logic [MW-1:0]              rerror_o;
    logic                       clear_i;
    logic                       init_done_o;

    modport master (
        output req_i, write_i, addr_i, wdata_i, wmask_i, clear_i,
        input  gnt_o, rvalid_o, rdata_o, rerror_o, init_done_o
    );

    modport slave (
        input  req_i, write_i, addr_i, wdata_i, wmask_i, clear_i,
        output gnt_o, rvalid_o, rdata_o, rerror_o, init_done_o
    );
endinterface

// File: rtl/i3c_table_mem_ram_1p.sv
// Single-port table storage: lane-masked write, registered read, out-of-range reads give 0.
// With I3C_TABLE_PARITY_EN each lane keeps an even-parity bit checked on read.
module i3c_table_ram_1p
    import i3c_table_mem_pkg::*;
#(
    parameter  int DEPTH              = DatTableDepth,
    parameter  int WIDTH              = DatTableWidth,
    parameter  int DATA_BITS_PER_MASK = TableMaskLane,
    localparam int AW                 = $clog2(DEPTH),
    localparam int MW                 = WIDTH / DATA_BITS_PER_MASK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [MW-1:0]    i_wmask,
    output logic [WIDTH-1:0] o_rdata,
    output logic [MW-1:0]    o_rerror
);
    localparam int B = DATA_BITS_PER_MASK;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [MW-1:0]    r_rerror;
    logic [MW-1:0]    w_par_err;
    logic             w_in_range;

    assign w_in_range = (32'(i_addr) < 32'(DEPTH));

    // Lane-masked write; addresses beyond DEPTH are dropped
    always_ff @(posedge clk_i) begin
        if (i_en && i_we && w_in_range) begin
            for (int l = 0; l < MW; l++) begin
                if (i_wmask[l]) begin
                    r_mem[i_addr][l*B +: B] <= i_wdata[l*B +: B];
                end
            end
        end
    end

`ifdef I3C_TABLE_PARITY_EN
    logic [MW-1:0] r_par [DEPTH];

    function automatic logic lane_parity(input logic [DATA_BITS_PER_MASK-1:0] d);
        return ^d;
    endfunction

    // Parity bits follow only the lanes that are written
    always_ff @(posedge clk_i) begin
        if (i_en && i_we && w_in_range) begin
            for (int l = 0; l < MW; l++) begin
                if (i_wmask[l]) begin
                    r_par[i_addr][l] <= lane_parity(i_wdata[l*B +: B]);
                end
            end
        end
    end

    // Recompute parity of the addressed entry for the read check
    always_comb begin
        w_par_err = '0;
        for (int l = 0; l < MW; l++) begin
            w_par_err[l] = w_in_range ? (lane_parity(r_mem[i_addr][l*B +: B]) ^ r_par[i_addr][l]) : 1'b0;
        end
    end
`else
    assign w_par_err = '0;
`endif

    // Registered read; data holds until the next read, error flags last one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_rerror <= '0;
        end else if (i_en && !i_we) begin
            r_rdata  <= w_in_range ? r_mem[i_addr] : '0;
            r_rerror <= w_par_err;
        end else begin
            r_rerror <= '0;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rerror = r_rerror;
endmodule

// File: rtl/i3c_table_mem.sv
// Shared DAT/DCT table memory: zero-fill FSM, round-robin arbiter and read-valid routing.
// Define I3C_TABLE_PARITY_EN to enable per-lane parity in the storage.
module i3c_table_mem
    import i3c_table_mem_pkg::*;
#(
    parameter int NUM_PORTS          = 2,
    parameter int DEPTH              = DatTableDepth,
    parameter int WIDTH              = DatTableWidth,
    parameter int DATA_BITS_PER_MASK = TableMaskLane
) (
    input  logic           clk_i,
    input  logic           rst_i,
    i3c_table_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = WIDTH / DATA_BITS_PER_MASK;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]           r_state;
    logic [AW-1:0]        r_init_cnt;
    logic [PW-1:0]        r_rr_ptr;
    logic                 r_init_done;
    logic [NUM_PORTS-1:0] r_rvalid;

    logic                 w_found;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [PW-1:0]        w_next_ptr;
    logic                 w_write;
    logic [AW-1:0]        w_addr;
    logic [WIDTH-1:0]     w_wdata;
    logic [MW-1:0]        w_wmask;

    // First requester at or after the pointer wins; nothing is granted while clearing
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_gnt      = '0;
        w_next_ptr = r_rr_ptr;
        w_write    = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_wmask    = '0;
        if (r_state == ST_SERVE && !bus.clear_i) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                v_idx = (int'(r_rr_ptr) + i) % NUM_PORTS;
                if (!w_found && bus.req_i[v_idx]) begin
                    w_found        = 1'b1;
                    w_gnt[v_idx]   = 1'b1;
                    w_next_ptr     = (v_idx == NUM_PORTS - 1) ? '0 : PW'(v_idx + 1);
                    w_write        = bus.write_i[v_idx];
                    w_addr         = bus.addr_i[v_idx*AW +: AW];
                    w_wdata        = bus.wdata_i[v_idx*WIDTH +: WIDTH];
                    w_wmask        = bus.wmask_i[v_idx*MW +: MW];
                end else begin
                    w_found = w_found;
                end
            end
        end else begin
            w_found = 1'b0;
        end
    end

    // Fill state, fill counter and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_init_done <= 1'b0;
        end else if (bus.clear_i) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == AW'(DEPTH - 1)) begin
                        r_state     <= ST_SERVE;
                        r_init_done <= 1'b1;
                        r_init_cnt  <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + AW'(1);
                    end
                end
                ST_SERVE: r_rr_ptr <= w_next_ptr;
                default:  r_state  <= ST_INIT;
            endcase
        end
    end

    // Read-valid goes back only to the port whose read was granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= (w_found && !w_write) ? w_gnt : '0;
        end
    end

    i3c_table_ram_1p #(
        .DEPTH              (DEPTH),
        .WIDTH              (WIDTH),
        .DATA_BITS_PER_MASK (DATA_BITS_PER_MASK)
    ) u_ram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_en     ((r_state == ST_INIT) ? 1'b1 : w_found),
        .i_we     ((r_state == ST_INIT) ? 1'b1 : w_write),
        .i_addr   ((r_state == ST_INIT) ? r_init_cnt : w_addr),
        .i_wdata  ((r_state == ST_INIT) ? '0 : w_wdata),
        .i_wmask  ((r_state == ST_INIT) ? '1 : w_wmask),
        .o_rdata  (bus.rdata_o),
        .o_rerror (bus.rerror_o)
    );

    assign bus.gnt_o       = w_gnt;
    assign bus.rvalid_o    = r_rvalid;
    assign bus.init_done_o = r_init_done;
endmodule
